keyboard_code_encoder: RTL and testbench



---
 rtl/keyboard_code_encoder.sv | 162 ++++++++++++++++
 tb/tb_keyboard_code_encoder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/keyboard_code_encoder.sv
// PS/2 set-2 scan-code to 4-bit key code encoder for the calculator keyboard path.
// Tracks E0/F0 prefixes, suppresses typematic repeats and strobes once per key press.
module keyboard_code_encoder #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [3:0] binary_val,
    output logic       key_valid,
    output logic       unknown_key
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    localparam logic [7:0] DIGIT_CODE [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic [3:0]       binary_val_reg, binary_val_next;
    logic             key_valid_reg, key_valid_next;
    logic             unknown_key_reg, unknown_key_next;
    logic [8:0]       held_reg, held_next;
    logic             held_valid_reg, held_valid_next;

    logic       ext_flag;
    logic       is_make;
    logic       is_break;
    logic       timeout_hit;
    logic [9:0] digit_hit;
    logic       map_hit;
    logic [3:0] map_val;
    logic       is_repeat;

    assign ext_flag    = (state_reg == EXT) || (state_reg == EXT_BRK);
    assign is_make     = scan_valid &&
                         (((state_reg == IDLE) && (scan_code != CODE_BRK) && (scan_code != CODE_EXT)) ||
                          ((state_reg == EXT) && (scan_code != CODE_BRK)));
    assign is_break    = scan_valid && ((state_reg == BRK) || (state_reg == EXT_BRK));
    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout_hit = !scan_valid && (state_reg != IDLE) && (count_reg == CNT_LAST);
    assign is_repeat   = held_valid_reg && (held_reg == {ext_flag, scan_code});

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_digit
            assign digit_hit[gi] = !ext_flag && (scan_code == DIGIT_CODE[gi]);
        end
    endgenerate

    always_comb begin
        map_hit = 1'b0;
        map_val = 4'h0;
        for (int i = 0; i < 10; i++) begin
            if (digit_hit[i]) begin
                map_hit = 1'b1;
                map_val = 4'(i);
            end
        end
        if (!ext_flag) begin
            case (scan_code)
                8'h79:   begin map_hit = 1'b1; map_val = 4'hA; end
                8'h7B:   begin map_hit = 1'b1; map_val = 4'hB; end
                8'h7C:   begin map_hit = 1'b1; map_val = 4'hC; end
                8'h21:   begin map_hit = 1'b1; map_val = 4'hE; end
                8'h5A:   begin map_hit = 1'b1; map_val = 4'hF; end
                default: ;
            endcase
        end else begin
            case (scan_code)
                8'h4A:   begin map_hit = 1'b1; map_val = 4'hD; end
                8'h5A:   begin map_hit = 1'b1; map_val = 4'hF; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (scan_valid) begin
            case (state_reg)
                IDLE: begin
                    if (scan_code == CODE_BRK)      state_next = BRK;
                    else if (scan_code == CODE_EXT) state_next = EXT;
                    else                            state_next = IDLE;
                end
                EXT:     state_next = (scan_code == CODE_BRK) ? EXT_BRK : IDLE;
                default: state_next = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        binary_val_next  = binary_val_reg;
        key_valid_next   = 1'b0;
        unknown_key_next = 1'b0;
        held_next        = held_reg;
        held_valid_next  = held_valid_reg;
        if (is_make) begin
            if (!map_hit) begin
                unknown_key_next = 1'b1;
            end else if (!is_repeat) begin
                binary_val_next = map_val;
                key_valid_next  = 1'b1;
                held_next       = {ext_flag, scan_code};
                held_valid_next = 1'b1;
            end
        end else if (is_break && is_repeat) begin
            held_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg       <= '0;
            binary_val_reg  <= 4'h0;
            key_valid_reg   <= 1'b0;
            unknown_key_reg <= 1'b0;
            held_reg        <= 9'h000;
            held_valid_reg  <= 1'b0;
        end else begin
            if (scan_valid || (state_reg == IDLE) || timeout_hit) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
            binary_val_reg  <= binary_val_next;
            key_valid_reg   <= key_valid_next;
            unknown_key_reg <= unknown_key_next;
            held_reg        <= held_next;
            held_valid_reg  <= held_valid_next;
        end
    end

    assign binary_val  = binary_val_reg;
    assign key_valid   = key_valid_reg;
    assign unknown_key = unknown_key_reg;

endmodule

// File: tb/tb_keyboard_code_encoder.sv
// Directed bench for keyboard_code_encoder: each step drives one cycle of input
// and inspects the registered response one clock later.
module tb_keyboard_code_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [3:0] binary_val;
    logic       key_valid;
    logic       unknown_key;

    int checks = 0;
    int errors = 0;
    int kv_cnt = 0;
    int uk_cnt = 0;

    keyboard_code_encoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .binary_val  (binary_val),
        .key_valid   (key_valid),
        .unknown_key (unknown_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle from a negedge, return at the next negedge with the response visible.
    task automatic step(input logic v, input logic [7:0] b);
        scan_valid = v;
        scan_code  = b;
        @(negedge clk);
        kv_cnt += int'(key_valid);
        uk_cnt += int'(unknown_key);
        if (key_valid && unknown_key) begin
            check("both_strobes", 32'(key_valid & unknown_key), 32'h0);
        end
        $display("step v=%0b byte=%02h -> binary_val=%0h key_valid=%0b unknown_key=%0b",
                 v, b, binary_val, key_valid, unknown_key);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic expect_out(input string tag, input logic kv, input logic uk, input logic [3:0] bv);
        check({tag, "_kv"}, 32'(key_valid), 32'(kv));
        check({tag, "_uk"}, 32'(unknown_key), 32'(uk));
        check({tag, "_bv"}, 32'(binary_val), 32'(bv));
    endtask

    logic [7:0] digit_codes [10];

    initial begin
        digit_codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        rst        = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        expect_out("reset", 1'b0, 1'b0, 4'h0);
        rst = 1'b0;

        // Make, break, and no strobe on break
        step(1'b1, 8'h16); expect_out("make16", 1'b1, 1'b0, 4'd1);
        step(1'b1, 8'hF0); expect_out("brk_pfx", 1'b0, 1'b0, 4'd1);
        step(1'b1, 8'h16); expect_out("brk16", 1'b0, 1'b0, 4'd1);
        idle(1);           expect_out("idle1", 1'b0, 1'b0, 4'd1);

        // Typematic suppression, release, press again
        kv_cnt = 0;
        step(1'b1, 8'h79); expect_out("plus1", 1'b1, 1'b0, 4'hA);
        step(1'b1, 8'h79); expect_out("plus_rep1", 1'b0, 1'b0, 4'hA);
        step(1'b1, 8'h79); expect_out("plus_rep2", 1'b0, 1'b0, 4'hA);
        step(1'b1, 8'hF0);
        step(1'b1, 8'h79); expect_out("plus_brk", 1'b0, 1'b0, 4'hA);
        step(1'b1, 8'h79); expect_out("plus2", 1'b1, 1'b0, 4'hA);
        check("plus_pulses", 32'(kv_cnt), 32'd2);

        // Other single-byte operators
        step(1'b1, 8'h7B); expect_out("minus", 1'b1, 1'b0, 4'hB);
        step(1'b1, 8'h7C); expect_out("mult", 1'b1, 1'b0, 4'hC);
        step(1'b1, 8'h21); expect_out("clear", 1'b1, 1'b0, 4'hE);

        // Extended codes
        step(1'b1, 8'hE0); expect_out("ext_pfx", 1'b0, 1'b0, 4'hE);
        step(1'b1, 8'h4A); expect_out("div", 1'b1, 1'b0, 4'hD);
        step(1'b1, 8'hE0);
        step(1'b1, 8'h4A); expect_out("div_rep", 1'b0, 1'b0, 4'hD);
        step(1'b1, 8'hE0);
        step(1'b1, 8'hF0);
        step(1'b1, 8'h4A); expect_out("div_brk", 1'b0, 1'b0, 4'hD);
        step(1'b1, 8'hE0);
        step(1'b1, 8'h4A); expect_out("div_again", 1'b1, 1'b0, 4'hD);
        step(1'b1, 8'h7B); expect_out("minus2", 1'b1, 1'b0, 4'hB);
        step(1'b1, 8'hE0);
        step(1'b1, 8'h5A); expect_out("kp_enter", 1'b1, 1'b0, 4'hF);
        step(1'b1, 8'h7B); expect_out("minus3", 1'b1, 1'b0, 4'hB);
        step(1'b1, 8'h5A); expect_out("enter", 1'b1, 1'b0, 4'hF);
        step(1'b1, 8'hE0);
        step(1'b1, 8'h16); expect_out("ext_unmapped", 1'b0, 1'b1, 4'hF);

        // Unmapped normal make
        step(1'b1, 8'h1C); expect_out("unknown1C", 1'b0, 1'b1, 4'hF);

        // Timeout: prefix abandoned after 16 idle cycles
        kv_cnt = 0;
        uk_cnt = 0;
        step(1'b1, 8'hE0);
        idle(16);
        check("to_quiet_kv", 32'(kv_cnt), 32'd0);
        check("to_quiet_uk", 32'(uk_cnt), 32'd0);
        step(1'b1, 8'h4A); expect_out("to_expired", 1'b0, 1'b1, 4'hF);

        // Byte in the expiry cycle wins over the timeout
        step(1'b1, 8'hE0);
        idle(15);
        step(1'b1, 8'h4A); expect_out("to_edge", 1'b1, 1'b0, 4'hD);

        // Reset mid-sequence discards the prefix
        step(1'b1, 8'hE0);
        rst = 1'b1;
        step(1'b0, 8'h00); expect_out("mid_rst", 1'b0, 1'b0, 4'h0);
        rst = 1'b0;
        step(1'b1, 8'h45); expect_out("after_rst", 1'b1, 1'b0, 4'd0);

        // Release 0, then all digits back to back
        step(1'b1, 8'hF0);
        step(1'b1, 8'h45);
        kv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, digit_codes[i]);
            check("digit_kv", 32'(key_valid), 32'h1);
            check("digit_bv", 32'(binary_val), 32'(i));
        end
        step(1'b0, 8'h00); expect_out("digits_done", 1'b0, 1'b0, 4'd9);
        check("digit_pulses", 32'(kv_cnt), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
